// File: rtl/ysyx_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Fixed latency: N iteration cycles plus one sign-correction cycle.
module ysyx_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] src1_in,
    input  logic [63:0] src2_in,
    input  logic        is_w,
    input  logic [1:0]  ALUctr_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;

    logic [6:0]  r_cnt;
    logic [63:0] r_quo;
    logic [63:0] r_rem;
    logic [63:0] r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_rem;
    logic        r_is_w;

    logic        w_signed;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        w_sa;
    logic        w_sb;
    logic [63:0] w_abs_a;
    logic [63:0] w_abs_b;

    logic [64:0] w_rem_sh;
    logic [64:0] w_diff;
    logic        w_ge;

    logic [63:0] w_qs;
    logic [63:0] w_rs;
    logic [63:0] w_res;
    logic [63:0] w_fin;

    assign in_ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 7'd1) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operands narrowed to the operating width, then reduced to magnitudes
    assign w_signed = ~ALUctr_in[0];
    assign w_a = is_w ? (w_signed ? {{32{src1_in[31]}}, src1_in[31:0]}
                                  : {32'b0, src1_in[31:0]})
                      : src1_in;
    assign w_b = is_w ? (w_signed ? {{32{src2_in[31]}}, src2_in[31:0]}
                                  : {32'b0, src2_in[31:0]})
                      : src2_in;
    assign w_sa    = w_signed & w_a[63];
    assign w_sb    = w_signed & w_b[63];
    assign w_abs_a = w_sa ? (64'd0 - w_a) : w_a;
    assign w_abs_b = w_sb ? (64'd0 - w_b) : w_b;

    assign w_rem_sh = {r_rem, r_quo[63]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_ge     = w_rem_sh[64] | ~w_diff[64];

    assign w_qs  = r_neg_q ? (64'd0 - r_quo) : r_quo;
    assign w_rs  = r_neg_r ? (64'd0 - r_rem) : r_rem;
    assign w_res = r_is_rem ? w_rs : w_qs;
    assign w_fin = r_is_w ? {{32{w_res[31]}}, w_res[31:0]} : w_res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= 7'd0;
            r_quo     <= 64'd0;
            r_rem     <= 64'd0;
            r_div     <= 64'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_is_w    <= 1'b0;
            out_valid <= 1'b0;
            result    <= 64'd0;
        end else if (w_accept) begin
            r_cnt     <= is_w ? 7'd32 : 7'd64;
            // W dividend sits in the top half so its MSB shifts out first
            r_quo     <= is_w ? {w_abs_a[31:0], 32'b0} : w_abs_a;
            r_rem     <= 64'd0;
            r_div     <= w_abs_b;
            r_neg_q   <= (w_sa ^ w_sb) & (w_b != 64'd0);
            r_neg_r   <= w_sa;
            r_is_rem  <= ALUctr_in[1];
            r_is_w    <= is_w;
            out_valid <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 7'd1;
            r_rem <= w_ge ? w_diff[63:0] : w_rem_sh[63:0];
            r_quo <= {r_quo[62:0], w_ge};
        end else if (r_state == S_FIX) begin
            result    <= w_fin;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_div_unit.sv
// Directed and randomized checks of ysyx_div_unit against an arithmetic
// reference model, including latency, handshake and reset behaviour.
module tb_ysyx_div_unit;

    logic        clk;
    logic        rst;
    logic [63:0] src1_in;
    logic [63:0] src2_in;
    logic        is_w;
    logic [1:0]  ALUctr_in;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;

    int tests;
    int fails;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    ysyx_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .src1_in   (src1_in),
        .src2_in   (src2_in),
        .is_w      (is_w),
        .ALUctr_in (ALUctr_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic w,
                                          input logic [1:0] op);
        int          sa, sb, sq, sr;
        int unsigned ua, ub, uq, ur;
        longint      la, lb, lq, lr;
        longint unsigned lua, lub, luq, lur;
        logic [31:0] r32;
        logic [63:0] r64;
        if (w) begin
            sa = int'(a[31:0]);
            sb = int'(b[31:0]);
            ua = a[31:0];
            ub = b[31:0];
            if (!op[0]) begin
                if (sb == 0) begin
                    sq = -1;
                    sr = sa;
                end else if (sa == int'(32'h80000000) && sb == -1) begin
                    sq = sa;
                    sr = 0;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                end
                r32 = op[1] ? sr : sq;
            end else begin
                if (ub == 0) begin
                    uq = 32'hFFFFFFFF;
                    ur = ua;
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                end
                r32 = op[1] ? ur : uq;
            end
            return {{32{r32[31]}}, r32};
        end
        la  = longint'(a);
        lb  = longint'(b);
        lua = a;
        lub = b;
        if (!op[0]) begin
            if (lb == 0) begin
                lq = -1;
                lr = la;
            end else if (a == 64'h8000000000000000 && lb == -1) begin
                lq = la;
                lr = 0;
            end else begin
                lq = la / lb;
                lr = la % lb;
            end
            r64 = op[1] ? lr : lq;
        end else begin
            if (lub == 0) begin
                luq = 64'hFFFFFFFFFFFFFFFF;
                lur = lua;
            end else begin
                luq = lua / lub;
                lur = lua % lub;
            end
            r64 = op[1] ? lur : luq;
        end
        return r64;
    endfunction

    // Issue one request and check it completes exactly N+1 edges later
    task automatic run_op(input string tag, input logic [63:0] a,
                          input logic [63:0] b, input logic w,
                          input logic [1:0] op, input logic [63:0] exp,
                          input logic hold);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk({tag, "_idle_timeout"}, {63'd0, in_ready}, 64'd1);
        end
        src1_in   = a;
        src2_in   = b;
        is_w      = w;
        ALUctr_in = op;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_acc_ovalid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_acc_ready"}, {63'd0, in_ready}, 64'd0);
        if (!hold) in_valid = 1'b0;
        lat = w ? 32 : 64;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (hold) begin
                src1_in   = {$urandom, $urandom};
                src2_in   = {$urandom, $urandom};
                is_w      = 1'($urandom);
                ALUctr_in = 2'($urandom);
            end
        end
        chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_ovalid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_result"}, result, exp);
    endtask

    initial begin
        logic [63:0] a, b;
        logic        w;
        logic [1:0]  op;
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        src1_in   = 64'd0;
        src2_in   = 64'd0;
        is_w      = 1'b0;
        ALUctr_in = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);

        rst = 1'b1;
        run_op("div_m7_2", 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b0, OP_DIV,
               64'hFFFFFFFFFFFFFFFD, 1'b0);
        run_op("rem_m7_2", 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b0, OP_REM,
               64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("divu_z", 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, OP_DIVU,
               64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("remu_z", 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, OP_REMU,
               64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("div_ovf", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0,
               OP_DIV, 64'h8000000000000000, 1'b0);
        run_op("rem_ovf", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0,
               OP_REM, 64'd0, 1'b0);
        run_op("divuw", 64'h00000000FFFFFFFE, 64'd1, 1'b1, OP_DIVU,
               64'hFFFFFFFFFFFFFFFE, 1'b0);
        run_op("remw", 64'h123456780000000B, 64'hFFFFFFFFFFFFFFFD, 1'b1,
               OP_REM, 64'd2, 1'b0);
        run_op("divw_ovf", 64'h0000000080000000, 64'h00000000FFFFFFFF, 1'b1,
               OP_DIV, 64'hFFFFFFFF80000000, 1'b0);
        run_op("remw_z", 64'h00000000F0000005, 64'd0, 1'b1, OP_REM,
               64'hFFFFFFFFF0000005, 1'b0);
        run_op("div_z", 64'hFFFFFFFFFFFFFF00, 64'd0, 1'b0, OP_DIV,
               64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("rem_neg", 64'd100, 64'hFFFFFFFFFFFFFFF9, 1'b0, OP_REM,
               64'd2, 1'b0);

        run_op("hold", 64'd1000, 64'd7, 1'b0, OP_DIVU, 64'd142, 1'b1);

        run_op("b2b_a", 64'd77, 64'd10, 1'b1, OP_REMU, 64'd7, 1'b0);
        run_op("b2b_b", 64'd81, 64'd9, 1'b0, OP_DIVU, 64'd9, 1'b0);

        src1_in   = 64'd12345;
        src2_in   = 64'd5;
        is_w      = 1'b0;
        ALUctr_in = OP_DIV;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_ovalid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", result, 64'd0);
        rst = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_no_done", {63'd0, out_valid}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            w  = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: begin
                    b = 64'hFFFFFFFFFFFFFFFF;
                    a = w ? 64'h0000000080000000 : 64'h8000000000000000;
                end
                2: b = 64'($urandom_range(1, 15));
                3: b = {32'd0, 32'($urandom_range(1, 1000))};
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), a, b, w, op, model(a, b, w, op),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_div_unit.md
YSYX_DIV_UNIT -- requirements
Module: ysyx_div_unit

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 64-bit (XLEN=64).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-low; clock clk.
REQ-004 src1_in  input  64  dividend.
REQ-005 src2_in  input  64  divisor.
REQ-006 is_w  input  1  1 = RV64 W-form (32-bit) operation.
REQ-007 ALUctr_in  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 in_valid  input  1  request valid; sampled only while in_ready=1.
REQ-009 in_ready  output  1  1 = idle, can accept a request.
REQ-010 out_valid  output  1  1 = result holds the last completed operation.
REQ-011 result  output  64  quotient or remainder.

Function
REQ-012 Accept a request at a rising edge when in_valid=1 and in_ready=1; latch src1_in, src2_in, is_w and ALUctr_in at that edge.
REQ-013 On acceptance, drive in_ready=0 and out_valid=0 from the next cycle; ignore input changes while busy.
REQ-014 Use an iterative restoring or non-restoring radix-2 algorithm, one quotient bit per cycle.
REQ-015 Iteration count N SHALL be 64 for 64-bit operations and 32 for W operations.
REQ-016 At the (N+1)-th rising edge after acceptance, which includes one sign-correction cycle, register result, set out_valid=1 and set in_ready=1.
REQ-017 The fixed latency SHALL apply to all operand values, including divide-by-zero and overflow.
REQ-018 out_valid and result SHALL hold until the next accepted request or reset.
REQ-019 A request accepted in the same cycle that out_valid=1 clears out_valid at that edge.
REQ-020 Signed ops (DIV, REM) use the magnitudes of both operands.
REQ-021 The quotient is negative iff the operand signs differ and the divisor is nonzero.
REQ-022 The remainder takes the sign of the dividend.
REQ-023 Quotient truncates toward zero.
REQ-024 W-form: operands are src[31:0], sign-extended for DIVW/REMW and zero-extended for DIVUW/REMUW.
REQ-025 W-form: the 32-bit result is sign-extended from bit 31 to 64 bits for all four W ops.
REQ-026 Divide by zero: quotient = all ones (-1 at the operating width), remainder = dividend (at the operating width, W-form then sign-extended).
REQ-027 Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
REQ-028 For W-form, the overflow case is 0x80000000 / 0xFFFFFFFF, giving result 0xFFFFFFFF80000000 for the quotient.
REQ-029 in_valid=0 while idle SHALL leave all state unchanged.

Reset
REQ-030 When rst=0 at a rising edge: abort any operation, in_ready=1, out_valid=0, result=0, internal counters and registers cleared.
REQ-031 Reset asserted mid-operation SHALL discard the operation; no out_valid follows.
REQ-032 The first request after reset release may be accepted on the first edge with rst=1.

Verification
REQ-033 DIV 64-bit, src1=-7 (0xFFFFFFFFFFFFFFF9), src2=2 -> after 65 edges, out_valid=1, result=0xFFFFFFFFFFFFFFFD (-3); REM on the same operands -> 0xFFFFFFFFFFFFFFFF (-1).
REQ-034 DIVU, src1=0xFFFFFFFFFFFFFFFF, src2=0 -> result=0xFFFFFFFFFFFFFFFF; REMU on the same operands -> 0xFFFFFFFFFFFFFFFF; latency 65 edges.
REQ-035 DIV, src1=0x8000000000000000, src2=-1 -> 0x8000000000000000; REM on the same operands -> 0.
REQ-036 DIVUW, src1=0x00000000FFFFFFFE, src2=1 -> result=0xFFFFFFFFFFFFFFFE after 33 edges.
REQ-037 REMW, src1=0x123456780000000B (low word 11), src2=-3 -> result=2.
REQ-038 Handshake: in_valid held high and operands changed while busy -> no effect on result.
REQ-039 Handshake: rst=0 mid-operation -> in_ready=1, out_valid=0, result=0 the next cycle.
REQ-040 Handshake: back-to-back request on the completion cycle -> accepted, out_valid drops for the full latency.
